// File: rtl/tt_probe_pkg.sv
// Shared types and constants for the truth-table prober.
package tt_probe_pkg;

    localparam int unsigned NMIN  = 16;  // minterms of a 4-input function
    localparam int unsigned TT_W  = 16;  // truth-table width
    localparam int unsigned CNT_W = 5;   // onset count width, holds 0..16

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DRAIN,
        DONE
    } state_t;

    // Minterm tag travelling alongside the DUT latency
    typedef struct packed {
        logic       valid;
        logic [3:0] idx;
    } tag_t;

endpackage

// File: rtl/tt_probe_delay.sv
// LAT-deep shift register of minterm tags; a plain wire when LAT is 0.
module tt_probe_delay
    import tt_probe_pkg::*;
#(
    parameter int unsigned LAT = 0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  tag_t tag_i,
    output tag_t tag_o
);

    if (LAT == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ rst_i;
        assign tag_o          = tag_i;
    end else begin : g_pipe
        tag_t pipe_q [LAT];
        tag_t pipe_d [LAT];

        // Shift: new tag enters stage 0, oldest leaves from the last stage
        always_comb begin
            pipe_d[0] = tag_i;
            for (int unsigned i = 1; i < LAT; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end

        // Only the valid bits need a reset; stale indices are harmless
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                for (int unsigned i = 0; i < LAT; i++) begin
                    pipe_q[i].valid <= 1'b0;
                end
            end else begin
                pipe_q <= pipe_d;
            end
        end

        assign tag_o = pipe_q[LAT-1];
    end

endmodule

// File: rtl/tt_prober.sv
// Sweeps x through all 16 minterms, captures y into a truth table,
// counts the onset and compares against an expected table.
module tt_prober
    import tt_probe_pkg::*;
#(
    parameter int unsigned LAT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [TT_W-1:0]  expect_tt,
    input  logic             y,
    output logic [3:0]       x,
    output logic             busy,
    output logic             done,
    output logic [TT_W-1:0]  tt,
    output logic [CNT_W-1:0] ones,
    output logic             pass
);

    localparam logic [3:0] LastMin = 4'(NMIN - 1);
    localparam logic [2:0] LatL    = 3'(LAT);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q,   cnt_d;
    logic [2:0]       drn_q,   drn_d;
    logic [TT_W-1:0]  exp_q,   exp_d;
    logic [TT_W-1:0]  tt_q,    tt_d;
    logic [CNT_W-1:0] ones_q,  ones_d;
    logic             pass_q,  pass_d;

    tag_t tag_in, tag_out;

    assign tag_in = '{valid: (state_q == SWEEP), idx: cnt_q};

    tt_probe_delay #(
        .LAT (LAT)
    ) u_delay (
        .clk_i (clk),
        .rst_i (rst),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    // Next state, capture and compare. DRAIN spans LAT+1 cycles so the final
    // capture is already in tt_q on the edge that enters DONE and computes pass.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drn_d   = drn_q;
        exp_d   = exp_q;
        tt_d    = tt_q;
        ones_d  = ones_q;
        pass_d  = pass_q;

        if (tag_out.valid) begin
            tt_d[tag_out.idx] = y;
            ones_d            = ones_q + CNT_W'(y);
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SWEEP;
                    exp_d   = expect_tt;
                    tt_d    = '0;
                    ones_d  = '0;
                    pass_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            SWEEP: begin
                cnt_d = cnt_q + 4'd1;  // wraps to 0 on the exit edge
                if (cnt_q == LastMin) begin
                    state_d = DRAIN;
                    drn_d   = '0;
                end
            end
            DRAIN: begin
                drn_d = drn_q + 3'd1;
                if (drn_q == LatL) begin
                    state_d = DONE;
                    pass_d  = (tt_q == exp_q);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            drn_q   <= '0;
            exp_q   <= '0;
            tt_q    <= '0;
            ones_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drn_q   <= drn_d;
            exp_q   <= exp_d;
            tt_q    <= tt_d;
            ones_q  <= ones_d;
            pass_q  <= pass_d;
        end
    end

    // Drive and status outputs decoded from state
    always_comb begin
        x    = 4'd0;
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            IDLE: ;
            SWEEP: begin
                x    = cnt_q;
                busy = 1'b1;
            end
            DRAIN: begin
                x    = LastMin;
                busy = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign tt   = tt_q;
    assign ones = ones_q;
    assign pass = pass_q;

endmodule

// File: tb/tb_tt_prober.sv
// Bench for tt_prober: a LAT=0 and a LAT=3 instance driven by modelled netlists.
module tb_tt_prober;

    localparam int FAND = 0, FX3 = 1, FONE = 2, FZERO = 3, FRND = 4, FPAR = 5;

    typedef struct {
        int          sel;
        int          fmode;
        logic [15:0] exp_tt;
        logic [15:0] want_tt;
        logic [4:0]  want_ones;
        logic        want_pass;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int          fmode  = FAND;
    logic [15:0] rnd_tt = '0;
    int          sel    = 0;

    // Instance 0: LAT = 0
    logic        start0 = 1'b0, y0, busy0, done0, pass0;
    logic [15:0] exp0 = '0, tt0;
    logic [3:0]  x0v;
    logic [4:0]  ones0;
    // Instance 3: LAT = 3
    logic        start3 = 1'b0, y3, busy3, done3, pass3;
    logic [15:0] exp3 = '0, tt3;
    logic [3:0]  x3v;
    logic [4:0]  ones3;
    logic        p1, p2;

    int n_chk  = 0;
    int n_fail = 0;
    int nd0    = 0;
    int nd3    = 0;

    tt_prober #(.LAT(0)) u_dut0 (
        .clk (clk), .rst (rst), .start (start0), .expect_tt (exp0), .y (y0),
        .x (x0v), .busy (busy0), .done (done0), .tt (tt0), .ones (ones0), .pass (pass0)
    );

    tt_prober #(.LAT(3)) u_dut3 (
        .clk (clk), .rst (rst), .start (start3), .expect_tt (exp3), .y (y3),
        .x (x3v), .busy (busy3), .done (done3), .tt (tt3), .ones (ones3), .pass (pass3)
    );

    // The netlist under probe, as a plain boolean function of the minterm
    function automatic logic dut_fn(input int mode, input logic [15:0] tbl, input logic [3:0] m);
        case (mode)
            FAND:    return m[0] & m[1];
            FX3:     return m[3];
            FONE:    return 1'b1;
            FZERO:   return 1'b0;
            FRND:    return tbl[m];
            default: return ^m;
        endcase
    endfunction

    // Reference: tabulate the function over all minterms
    function automatic logic [15:0] model_tt(input int mode, input logic [15:0] tbl);
        logic [15:0] r;
        for (int m = 0; m < 16; m++) r[m] = dut_fn(mode, tbl, 4'(m));
        return r;
    endfunction

    always_comb y0 = dut_fn(fmode, rnd_tt, x0v);

    // Three-cycle registered netlist for the LAT=3 instance
    always @(posedge clk) begin
        p1 <= dut_fn(fmode, rnd_tt, x3v);
        p2 <= p1;
        y3 <= p2;
    end

    always @(negedge clk) begin
        if (done0) nd0 <= nd0 + 1;
        if (done3) nd3 <= nd3 + 1;
    end

    logic        s_done, s_busy, s_pass;
    logic [3:0]  s_x;
    logic [15:0] s_tt;
    logic [4:0]  s_ones;
    always_comb begin
        s_done = (sel == 1) ? done3 : done0;
        s_busy = (sel == 1) ? busy3 : busy0;
        s_pass = (sel == 1) ? pass3 : pass0;
        s_x    = (sel == 1) ? x3v   : x0v;
        s_tt   = (sel == 1) ? tt3   : tt0;
        s_ones = (sel == 1) ? ones3 : ones0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    task automatic drive_start(input int s, input logic v, input logic [15:0] e);
        if (s == 1) begin
            start3 = v;
            if (v) exp3 = e;
        end else begin
            start0 = v;
            if (v) exp0 = e;
        end
    endtask

    // One full sweep; repulse > 0 re-asserts start (other expect) at edge k+repulse
    task automatic run_sweep(input int s, input logic [15:0] e, input logic [15:0] wtt,
                             input logic [4:0] wones, input logic wpass, input int repulse,
                             input string name);
        int lat;
        int c;
        int xbad;
        lat = (s == 1) ? 3 : 0;
        sel = s;
        @(negedge clk);
        drive_start(s, 1'b1, e);
        @(negedge clk);
        drive_start(s, 1'b0, e);
        c    = 0;
        xbad = 0;
        chk({name, "_busy"}, 32'(s_busy), 1);
        while (!s_done && c < 60) begin
            if (c < 16 && s_x != 4'(c)) xbad++;
            if (c == 16 && s_x != 4'hF) xbad++;
            if (repulse > 0 && c == repulse - 1) drive_start(s, 1'b1, ~e);
            @(negedge clk);
            if (repulse > 0 && c == repulse - 1) drive_start(s, 1'b0, e);
            c++;
        end
        chk({name, "_xseq"}, 32'(xbad), 0);
        chk({name, "_lat"}, 32'(c), 32'(17 + lat));
        chk({name, "_tt"}, 32'(s_tt), 32'(wtt));
        chk({name, "_ones"}, 32'(s_ones), 32'(wones));
        chk({name, "_pass"}, 32'(s_pass), 32'(wpass));
        chk({name, "_busy_done"}, 32'(s_busy), 0);
        @(negedge clk);
        chk({name, "_pulse"}, 32'(s_done), 0);
        chk({name, "_hold"}, 32'(s_tt), 32'(wtt));
    endtask

    vec_t vecs [7];

    initial begin
        int          c, first, second, nd_before;
        logic [15:0] e, w;

        vecs[0] = '{0, FAND,  16'h8888, 16'h8888, 5'd4,  1'b1};
        vecs[1] = '{1, FPAR,  16'h6996, 16'h6996, 5'd8,  1'b1};
        vecs[2] = '{0, FX3,   16'hFF01, 16'hFF00, 5'd8,  1'b0};
        vecs[3] = '{0, FONE,  16'hFFFF, 16'hFFFF, 5'd16, 1'b1};
        vecs[4] = '{0, FZERO, 16'h0000, 16'h0000, 5'd0,  1'b1};
        vecs[5] = '{1, FONE,  16'h1234, 16'hFFFF, 5'd16, 1'b0};
        vecs[6] = '{1, FZERO, 16'h0000, 16'h0000, 5'd0,  1'b1};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_x0", 32'(x0v), 0);
        chk("rst_busy0", 32'(busy0), 0);
        chk("rst_done0", 32'(done0), 0);
        chk("rst_tt0", 32'(tt0), 0);
        chk("rst_ones3", 32'(ones3), 0);
        chk("rst_pass3", 32'(pass3), 0);
        chk("rst_busy3", 32'(busy3), 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors
        for (int i = 0; i < 7; i++) begin
            fmode = vecs[i].fmode;
            run_sweep(vecs[i].sel, vecs[i].exp_tt, vecs[i].want_tt, vecs[i].want_ones,
                      vecs[i].want_pass, 0, $sformatf("vec%0d", i));
        end

        // start re-pulsed at k+5 with a different expect: ignored
        fmode     = FAND;
        nd_before = nd0;
        run_sweep(0, 16'h8888, 16'h8888, 5'd4, 1'b1, 5, "repulse");
        repeat (3) @(negedge clk);
        chk("repulse_ndone", 32'(nd0 - nd_before), 1);
        chk("repulse_idle", 32'(busy0), 0);

        // Reset at k+8 mid-sweep discards everything
        fmode = FONE;
        sel   = 0;
        @(negedge clk);
        start0 = 1'b1;
        exp0   = 16'hFFFF;
        @(negedge clk);
        start0 = 1'b0;
        for (int i = 0; i < 7; i++) @(negedge clk);
        rst = 1'b1;
        nd_before = nd0;
        @(negedge clk);
        chk("midrst_x", 32'(x0v), 0);
        chk("midrst_busy", 32'(busy0), 0);
        chk("midrst_tt", 32'(tt0), 0);
        chk("midrst_ones", 32'(ones0), 0);
        chk("midrst_done", 32'(done0), 0);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("midrst_nodone", 32'(nd0 - nd_before), 0);
        run_sweep(0, 16'hFFFF, 16'hFFFF, 5'd16, 1'b1, 0, "after_rst");

        // start held high: back-to-back sweeps with one IDLE cycle between
        fmode = FX3;
        sel   = 0;
        @(negedge clk);
        start0 = 1'b1;
        exp0   = 16'hFF00;
        @(negedge clk);
        c      = 0;
        first  = -1;
        second = -1;
        while (second < 0 && c < 100) begin
            if (done0) begin
                if (first < 0) first = c;
                else second = c;
            end
            if (second < 0) begin
                @(negedge clk);
                c++;
            end
        end
        start0 = 1'b0;
        chk("b2b_first", 32'(first), 17);
        chk("b2b_second", 32'(second), 36);
        chk("b2b_tt", 32'(tt0), 32'h0000FF00);
        chk("b2b_pass", 32'(pass0), 1);
        repeat (3) @(negedge clk);
        chk("b2b_stop", 32'(busy0), 0);

        // Randomised tables against the tabulating model
        for (int i = 0; i < 12; i++) begin
            int s;
            s      = int'($urandom_range(0, 1));
            fmode  = FRND;
            rnd_tt = 16'($urandom);
            w      = model_tt(FRND, rnd_tt);
            e      = ($urandom_range(0, 1) == 1) ? w : 16'($urandom);
            run_sweep(s, e, w, 5'($countones(w)), (e == w), 0, $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
